jstk2_cursor_ctrl: RTL
======================

// Module: jstk2_cursor_ctrl
// PURPOSE
//  Downstream consumer of the JSTK2 SPI driver. Periodically requests a packet (o_fetch), captures the 7-byte rx bus on done,
//  decodes X/Y (10-bit) + buttons, applies deadzone, steps a clamped grid cursor, emits paint/clear pulses for the painter.
//  Watchdog flags a driver that never returns done.
// PARAMETERS
//  TOTAL_DATA_BYTE  7          bytes on i_rx_data
//  DATA_WIDTH       8          bits per byte
//  POLL_PERIOD      5_000_000  clocks between fetch starts (IDLE dwell); >=1
//  TIMEOUT          200_000    max clocks in FETCH awaiting i_done
//  GRID_W           64         cursor columns; x in [0,GRID_W-1]
//  GRID_H           48         cursor rows;    y in [0,GRID_H-1]
//  DEADZONE         128        |axis-512| below this => no step
// PORTS
//  i_clk           in   1     system clock
//  i_n_reset       in   1     asynchronous, active-low reset
//  i_enable        in   1     polling enable (level)
//  o_fetch         out  1     fetch request to driver
//  i_done          in   1     driver transaction done
//  i_rx_data       in   TOTAL_DATA_BYTE*DATA_WIDTH  packet; first-received byte at MSB [55:48]
//  o_cursor_x      out  $clog2(GRID_W)  current column
//  o_cursor_y      out  $clog2(GRID_H)  current row
//  o_cursor_valid  out  1     1-cycle pulse: packet applied (x/y valid this cycle)
//  o_paint         out  1     1-cycle pulse: trigger button rising edge
//  o_clear         out  1     1-cycle pulse: stick button rising edge
//  o_timeout       out  1     sticky: FETCH exceeded TIMEOUT; cleared on next good packet
// BEHAVIOUR
//  Reset (async, any state): FSM->IDLE, poll cnt=0, o_fetch=0, x=GRID_W/2, y=GRID_H/2, pulses=0, o_timeout=0, btn_prev=0.
//  Packet bytes: B0=X[7:0], B1[1:0]=X[9:8], B2=Y[7:0], B3[1:0]=Y[9:8], B4[0]=trigger, B4[1]=stick btn; B5,B6 ignored.
//  FSM:
//   IDLE   : poll cnt counts while i_enable; at POLL_PERIOD-1 -> FETCH, cnt=0. i_enable=0 holds cnt at 0.
//   FETCH  : o_fetch=1 (registered, held). i_done=1 -> CAPTURE (latch i_rx_data that cycle).
//            wait cnt reaches TIMEOUT-1 -> o_timeout=1, o_fetch=0, -> IDLE (no cursor change).
//            i_enable drop in FETCH does NOT abort: SPI transaction completes normally.
//   CAPTURE: compute steps from latched packet (combinational decode) -> UPDATE.
//   UPDATE : apply x/y, pulse o_cursor_valid, o_paint/o_clear as applicable, clear o_timeout, update btn_prev -> IDLE.
//  Latency: i_done high at cycle N -> o_fetch low N+1, outputs updated/pulsed N+2.
//  Step rule (10-bit unsigned, centre 512): axis>=512+DEADZONE -> +1; axis<=512-DEADZONE -> -1; else 0.
//   X: +1 = right. Y: stick up (high value) = y-1 (screen rows grow downward).
//   Clamp: x never <0 or >GRID_W-1; saturate, no wrap. Same for y. Both axes may step same packet (diagonal).
//  Buttons: edge vs btn_prev from last applied packet; held button => single pulse. Timed-out polls leave btn_prev.
//  Simultaneous: paint and move same packet -> o_paint with o_cursor_valid, x/y already the new position.
//  paint+clear same packet -> both pulse; consumer prioritises clear.
//  Max one transaction outstanding; o_fetch never reasserts until back in IDLE and poll period elapsed.
// STRUCTURE
//  Shared package jstk2_pkg: byte index localparams (X_LO..BTN), AXIS_CENTRE=512, AXIS_W=10, BTN_TRIG/BTN_STICK bits,
//  FSM state encoding (IDLE, FETCH, CAPTURE, UPDATE).
//  One sub-module: jstk2_axis_decode (combinational: 10-bit axis + DEADZONE -> signed 2-bit step), instanced twice.
//  Poll/timeout counters inline (single shared counter, cleared on state change).
// TESTING
//  1 Reset mid-FETCH (o_fetch=1): drop i_n_reset async -> o_fetch=0 immediately, x=32, y=24, FSM IDLE.
//  2 POLL_PERIOD=10, driver model done after 20 clk, X=1000,Y=512,B4=0 -> o_fetch rises 10 clk after enable,
//    o_cursor_valid 2 clk after done, x=33, y=24, no paint.
//  3 X=0 for 40 packets from x=32 -> x decrements to 0 and stays 0; Y=1023 from y=1 -> y=0 then saturates.
//  4 X=512+127 (inside DEADZONE) -> no step; X=640 -> +1; X=384 -> -1.
//  5 B4=01 on 3 consecutive packets -> o_paint once; B4=00 then 01 -> second pulse; B4=11 -> paint+clear.
//  6 TIMEOUT=50, driver never asserts done -> o_fetch drops at cycle 50, o_timeout=1, cursor unchanged;
//    next good packet clears o_timeout.

Source files
------------

// File: rtl/jstk2_pkg.sv
// Shared definitions for the JSTK2 cursor controller: packet layout, axis constants, FSM states.
package jstk2_pkg;

  // Byte positions within the rx packet, counted in order of reception
  localparam int unsigned X_LO = 0;
  localparam int unsigned X_HI = 1;
  localparam int unsigned Y_LO = 2;
  localparam int unsigned Y_HI = 3;
  localparam int unsigned BTN  = 4;

  localparam int unsigned AXIS_W      = 10;
  localparam int unsigned AXIS_CENTRE = 512;

  // Bit positions inside the button byte
  localparam int unsigned BTN_TRIG  = 0;
  localparam int unsigned BTN_STICK = 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    CAPTURE = 2'd2,
    UPDATE  = 2'd3
  } state_t;

  // Decoded packet fields that are actually consumed
  typedef struct packed {
    logic [AXIS_W-1:0] x;
    logic [AXIS_W-1:0] y;
    logic              trig;
    logic              stick;
  } pkt_t;

endpackage

// File: rtl/jstk2_axis_decode.sv
// Combinational axis decoder: 10-bit joystick axis -> signed step (-1, 0, +1) outside the deadzone.
module jstk2_axis_decode
  import jstk2_pkg::*;
#(
  parameter int unsigned DEADZONE = 128
) (
  input  logic [AXIS_W-1:0] i_axis,
  output logic signed [1:0] o_step_c
);

  localparam int unsigned HI_TH = AXIS_CENTRE + DEADZONE;
  // A deadzone wider than the centre value can never produce a negative step
  localparam bit          LO_EN = (DEADZONE <= AXIS_CENTRE);
  localparam int unsigned LO_TH = LO_EN ? (AXIS_CENTRE - DEADZONE) : 0;

  logic [31:0] w_axis;

  assign w_axis = 32'(i_axis);

  // Threshold compare; positive side wins if thresholds ever overlap
  always_comb begin
    o_step_c = 2'sb00;
    if (w_axis >= HI_TH) begin
      o_step_c = 2'sb01;
    end else if (LO_EN && (w_axis <= LO_TH)) begin
      o_step_c = 2'sb11;
    end
  end

endmodule

// File: rtl/jstk2_cursor_ctrl.sv
// JSTK2 cursor controller: polls the SPI driver, decodes stick/buttons, moves a clamped grid cursor.
module jstk2_cursor_ctrl
  import jstk2_pkg::*;
#(
  parameter int unsigned TOTAL_DATA_BYTE = 7,
  parameter int unsigned DATA_WIDTH      = 8,
  parameter int unsigned POLL_PERIOD     = 5_000_000,
  parameter int unsigned TIMEOUT         = 200_000,
  parameter int unsigned GRID_W          = 64,
  parameter int unsigned GRID_H          = 48,
  parameter int unsigned DEADZONE        = 128
) (
  input  logic                                  i_clk,
  input  logic                                  i_n_reset,
  input  logic                                  i_enable,
  output logic                                  o_fetch,
  input  logic                                  i_done,
  input  logic [TOTAL_DATA_BYTE*DATA_WIDTH-1:0] i_rx_data,
  output logic [$clog2(GRID_W)-1:0]             o_cursor_x,
  output logic [$clog2(GRID_H)-1:0]             o_cursor_y,
  output logic                                  o_cursor_valid,
  output logic                                  o_paint,
  output logic                                  o_clear,
  output logic                                  o_timeout
);

  localparam int unsigned XW       = $clog2(GRID_W);
  localparam int unsigned YW       = $clog2(GRID_H);
  localparam int unsigned CNT_MAX  = (POLL_PERIOD > TIMEOUT) ? POLL_PERIOD : TIMEOUT;
  localparam int unsigned CNT_W    = $clog2(CNT_MAX + 1);
  localparam int unsigned HI_W     = AXIS_W - DATA_WIDTH;
  // First-received byte sits at the top of the bus
  localparam int unsigned X_LO_LSB = (TOTAL_DATA_BYTE - 1 - X_LO) * DATA_WIDTH;
  localparam int unsigned X_HI_LSB = (TOTAL_DATA_BYTE - 1 - X_HI) * DATA_WIDTH;
  localparam int unsigned Y_LO_LSB = (TOTAL_DATA_BYTE - 1 - Y_LO) * DATA_WIDTH;
  localparam int unsigned Y_HI_LSB = (TOTAL_DATA_BYTE - 1 - Y_HI) * DATA_WIDTH;
  localparam int unsigned BTN_LSB  = (TOTAL_DATA_BYTE - 1 - BTN) * DATA_WIDTH;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic              r_fetch;
  logic              w_fetch_nxt;
  pkt_t              r_pkt;
  pkt_t              w_pkt_nxt;
  pkt_t              w_rx_pkt;
  logic [XW-1:0]     r_x;
  logic [XW-1:0]     w_x_nxt;
  logic [YW-1:0]     r_y;
  logic [YW-1:0]     w_y_nxt;
  logic              r_valid;
  logic              w_valid_nxt;
  logic              r_paint;
  logic              w_paint_nxt;
  logic              r_clear;
  logic              w_clear_nxt;
  logic              r_timeout;
  logic              w_timeout_nxt;
  logic [1:0]        r_btn_prev;
  logic [1:0]        w_btn_prev_nxt;
  logic signed [1:0] w_step_x;
  logic signed [1:0] w_step_y;
  logic [XW-1:0]     w_x_moved;
  logic [YW-1:0]     w_y_moved;
  logic              w_unused_rx;

  // Padding bits of the hi/button bytes and the trailing bytes carry nothing we use
  assign w_unused_rx = ^i_rx_data;

  // Slice the live rx bus into the fields we keep
  always_comb begin
    w_rx_pkt.x     = {i_rx_data[X_HI_LSB +: HI_W], i_rx_data[X_LO_LSB +: DATA_WIDTH]};
    w_rx_pkt.y     = {i_rx_data[Y_HI_LSB +: HI_W], i_rx_data[Y_LO_LSB +: DATA_WIDTH]};
    w_rx_pkt.trig  = i_rx_data[BTN_LSB + BTN_TRIG];
    w_rx_pkt.stick = i_rx_data[BTN_LSB + BTN_STICK];
  end

  jstk2_axis_decode #(.DEADZONE(DEADZONE)) u_dec_x (
    .i_axis   (r_pkt.x),
    .o_step_c (w_step_x)
  );

  jstk2_axis_decode #(.DEADZONE(DEADZONE)) u_dec_y (
    .i_axis   (r_pkt.y),
    .o_step_c (w_step_y)
  );

  // Saturating column step: positive X moves right
  always_comb begin
    w_x_moved = r_x;
    if ((w_step_x == 2'sb01) && (r_x != XW'(GRID_W - 1))) begin
      w_x_moved = r_x + XW'(1);
    end else if ((w_step_x == 2'sb11) && (r_x != '0)) begin
      w_x_moved = r_x - XW'(1);
    end
  end

  // Saturating row step: stick up decrements the row (rows grow downward)
  always_comb begin
    w_y_moved = r_y;
    if ((w_step_y == 2'sb01) && (r_y != '0)) begin
      w_y_moved = r_y - YW'(1);
    end else if ((w_step_y == 2'sb11) && (r_y != YW'(GRID_H - 1))) begin
      w_y_moved = r_y + YW'(1);
    end
  end

  // State and output registers
  always_ff @(posedge i_clk or negedge i_n_reset) begin
    if (!i_n_reset) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_fetch    <= 1'b0;
      r_pkt      <= '0;
      r_x        <= XW'(GRID_W / 2);
      r_y        <= YW'(GRID_H / 2);
      r_valid    <= 1'b0;
      r_paint    <= 1'b0;
      r_clear    <= 1'b0;
      r_timeout  <= 1'b0;
      r_btn_prev <= 2'b00;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_fetch    <= w_fetch_nxt;
      r_pkt      <= w_pkt_nxt;
      r_x        <= w_x_nxt;
      r_y        <= w_y_nxt;
      r_valid    <= w_valid_nxt;
      r_paint    <= w_paint_nxt;
      r_clear    <= w_clear_nxt;
      r_timeout  <= w_timeout_nxt;
      r_btn_prev <= w_btn_prev_nxt;
    end
  end

  // Next-state and next-output logic. Cursor/pulse registers load on the CAPTURE->UPDATE
  // edge so they are visible for exactly the UPDATE cycle.
  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_fetch_nxt    = r_fetch;
    w_pkt_nxt      = r_pkt;
    w_x_nxt        = r_x;
    w_y_nxt        = r_y;
    w_valid_nxt    = 1'b0;
    w_paint_nxt    = 1'b0;
    w_clear_nxt    = 1'b0;
    w_timeout_nxt  = r_timeout;
    w_btn_prev_nxt = r_btn_prev;
    case (r_state)
      IDLE: begin
        if (!i_enable) begin
          w_cnt_nxt = '0;
        end else if (r_cnt == CNT_W'(POLL_PERIOD - 1)) begin
          w_state_nxt = FETCH;
          w_cnt_nxt   = '0;
          w_fetch_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      FETCH: begin
        if (i_done) begin
          w_state_nxt = CAPTURE;
          w_cnt_nxt   = '0;
          w_fetch_nxt = 1'b0;
          w_pkt_nxt   = w_rx_pkt;
        end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
          w_state_nxt   = IDLE;
          w_cnt_nxt     = '0;
          w_fetch_nxt   = 1'b0;
          w_timeout_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      CAPTURE: begin
        w_state_nxt    = UPDATE;
        w_x_nxt        = w_x_moved;
        w_y_nxt        = w_y_moved;
        w_valid_nxt    = 1'b1;
        w_paint_nxt    = r_pkt.trig & ~r_btn_prev[BTN_TRIG];
        w_clear_nxt    = r_pkt.stick & ~r_btn_prev[BTN_STICK];
        w_timeout_nxt  = 1'b0;
        w_btn_prev_nxt = {r_pkt.stick, r_pkt.trig};
      end
      UPDATE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign o_fetch        = r_fetch;
  assign o_cursor_x     = r_x;
  assign o_cursor_y     = r_y;
  assign o_cursor_valid = r_valid;
  assign o_paint        = r_paint;
  assign o_clear        = r_clear;
  assign o_timeout      = r_timeout;

endmodule
